// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one 32-bit add/sub between NREQ requesters.
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [31:0]       rsp_sum,
  output logic              rsp_cout,
  output logic              rsp_zero,
  output logic              rsp_ovf
);
  logic [ID_W-1:0] ptr, g;
  logic [ID_W:0] idx;
  logic hit, hs, sub, cout, ovf;
  logic [31:0] a, b, beff, sum;
  // Scan downward in offset so the smallest offset from ptr is the final winner.
  always_comb begin
    g = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      idx = (idx >= (ID_W+1)'(NREQ)) ? idx - (ID_W+1)'(NREQ) : idx;
      if (req_valid[idx[ID_W-1:0]]) begin
        g = idx[ID_W-1:0];
        hit = 1'b1;
      end
    end
  end
  assign hs = rst_n && hit && (!rsp_valid || rsp_ready);
  assign req_ready = hs ? (NREQ'(1) << g) : '0;
  always_comb begin
    a = '0;
    b = '0;
    sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (hit && g == ID_W'(i)) begin
        a = req_a[32*i +: 32];
        b = req_b[32*i +: 32];
        sub = req_sub[i];
      end
    end
  end
  assign beff = b ^ {32{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, beff} + 33'(sub);
  assign ovf = (a[31] == beff[31]) && (sum[31] != a[31]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf <= 1'b0;
      ptr <= '0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_id <= g;
      rsp_sum <= sum;
      rsp_cout <= cout;
      rsp_zero <= (sum == '0);
      rsp_ovf <= ovf;
      ptr <= (g == ID_W'(NREQ - 1)) ? '0 : g + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed vector table plus arbitration/backpressure/reset sequences.
module tb_adder_share_arb;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready, req_sub;
  logic [127:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_ovf;
  logic [1:0] rsp_id;
  logic [31:0] rsp_sum;
  int tests = 0;
  int errors = 0;

  adder_share_arb #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    logic [31:0] a, b;
    logic sub;
    logic [31:0] sum;
    logic cout, zero, ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 32'd5,          32'd3,          1'b0, 32'd8,          1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 32'h12345678,   32'h12345678,   1'b1, 32'h0,          1'b1, 1'b1, 1'b0};
    vecs[2] = '{0, 32'h7FFFFFFF,   32'd1,          1'b0, 32'h80000000,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 32'd0,          32'd1,          1'b1, 32'hFFFFFFFF,   1'b0, 1'b0, 1'b0};
    vecs[4] = '{2, 32'hFFFFFFFF,   32'd1,          1'b0, 32'h0,          1'b1, 1'b1, 1'b0};
    vecs[5] = '{3, 32'h80000000,   32'd1,          1'b1, 32'h7FFFFFFF,   1'b1, 1'b0, 1'b1};
    vecs[6] = '{1, 32'd10,         32'd3,          1'b1, 32'd7,          1'b1, 1'b0, 1'b0};
    vecs[7] = '{3, 32'h80000000,   32'h80000000,   1'b0, 32'h0,          1'b1, 1'b1, 1'b1};
    rst_n = 1'b0;
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = 1'b1;
    #12;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    next_edge();
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd0);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    next_edge();
    foreach (vecs[v]) begin
      req_valid = 4'(1) << vecs[v].id;
      req_a[32*vecs[v].id +: 32] = vecs[v].a;
      req_b[32*vecs[v].id +: 32] = vecs[v].b;
      req_sub[vecs[v].id] = vecs[v].sub;
      @(negedge clk);
      check($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(4'(1) << vecs[v].id));
      next_edge();
      req_valid = '0;
      check($sformatf("vec%0d_valid", v), 64'(rsp_valid), 64'd1);
      check($sformatf("vec%0d_id", v), 64'(rsp_id), 64'(vecs[v].id));
      check($sformatf("vec%0d_sum", v), 64'(rsp_sum), 64'(vecs[v].sum));
      check($sformatf("vec%0d_cout", v), 64'(rsp_cout), 64'(vecs[v].cout));
      check($sformatf("vec%0d_zero", v), 64'(rsp_zero), 64'(vecs[v].zero));
      check($sformatf("vec%0d_ovf", v), 64'(rsp_ovf), 64'(vecs[v].ovf));
    end
    // Last vector granted requester 3, so the pointer is back at 0.
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'(i);
      req_b[32*i +: 32] = 32'd100;
    end
    req_sub = '0;
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(4'(1) << (k % 4)));
      next_edge();
      check($sformatf("rr%0d_id", k), 64'(rsp_id), 64'(k % 4));
      check($sformatf("rr%0d_sum", k), 64'(rsp_sum), 64'(100 + k % 4));
    end
    req_valid = 4'b1100;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
      check($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d_id", k), 64'(rsp_id), 64'd1);
      check($sformatf("bp%0d_sum", k), 64'(rsp_sum), 64'd101);
      next_edge();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_refill_ready", 64'(req_ready), 64'b0100);
    next_edge();
    check("bp_refill_id", 64'(rsp_id), 64'd2);
    check("bp_refill_sum", 64'(rsp_sum), 64'd102);
    req_valid = 4'b0001;
    @(negedge clk);
    check("wrap_ready", 64'(req_ready), 64'b0001);
    next_edge();
    check("wrap_id", 64'(rsp_id), 64'd0);
    req_valid = 4'b1001;
    @(negedge clk);
    check("sparse_ready", 64'(req_ready), 64'b1000);
    next_edge();
    check("sparse_id", 64'(rsp_id), 64'd3);
    check("sparse_sum", 64'(rsp_sum), 64'd103);
    req_valid = '0;
    next_edge();
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_sum_held", 64'(rsp_sum), 64'd103);
    req_valid = 4'b0001;
    next_edge();
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(rsp_valid), 64'd0);
    check("async_reset_ready", 64'(req_ready), 64'd0);
    check("async_reset_sum", 64'(rsp_sum), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
